pipeline_fd_skid: RTL and testbench

PIPELINE_FD_SKID -- requirements
Module: pipeline_fd_skid

---
 rtl/pipeline_fd_skid.sv | 122 ++++++++++++
 tb/tb_pipeline_fd_skid.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_fd_skid.sv
// Fetch-to-decode pipeline register with a one-entry skid buffer.
// Fully registered ready/valid in both directions; flush empties the stage and presents a NOP.
module pipeline_fd_skid #(
  parameter int unsigned         XLEN      = 32,
  parameter logic [XLEN-1:0]     RESET_PC  = XLEN'(32'h1000_0000),
  parameter logic [XLEN-1:0]     NOP_INSTR = XLEN'(32'h0000_0033),
  parameter int unsigned         SB_W      = 2
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   InstrF,
  input  logic [XLEN-1:0]   PCF,
  input  logic [XLEN-1:0]   PC_Plus4F,
  input  logic [SB_W-1:0]   SbF,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   InstrD,
  output logic [XLEN-1:0]   PCD,
  output logic [XLEN-1:0]   PC_Plus4D,
  output logic [SB_W-1:0]   SbD,
  output logic [1:0]        occupancy
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc4;
    logic [SB_W-1:0] sb;
  } beat_t;

  localparam logic [XLEN-1:0] RESET_PC4 = RESET_PC + XLEN'(4);

  state_t state, nxt_state;
  beat_t  head, nxt_head;
  beat_t  skid, nxt_skid;
  beat_t  in_beat;
  logic   valid_q, nxt_valid;
  logic   ready_q, nxt_ready;
  logic   push, pop;

  // State and storage registers; ready/valid flops track the next state.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state   <= EMPTY;
      head    <= '{instr: NOP_INSTR, pc: RESET_PC, pc4: RESET_PC4, sb: '0};
      skid    <= '0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state   <= nxt_state;
      head    <= nxt_head;
      skid    <= nxt_skid;
      valid_q <= nxt_valid;
      ready_q <= nxt_ready;
    end
  end

  // Next-state and storage update; an emptied head shows a NOP with cleared sideband.
  always_comb begin
    nxt_state = state;
    nxt_head  = head;
    nxt_skid  = skid;
    in_beat   = '{instr: InstrF, pc: PCF, pc4: PC_Plus4F, sb: SbF};
    push      = in_valid & ready_q & ~flush;
    pop       = valid_q & out_ready & ~flush;

    if (flush) begin
      nxt_state      = EMPTY;
      nxt_head.instr = NOP_INSTR;
      nxt_head.sb    = '0;
    end else begin
      case (state)
        EMPTY: begin
          if (push) begin
            nxt_head  = in_beat;
            nxt_state = ONE;
          end
        end
        ONE: begin
          if (push && pop) begin
            nxt_head = in_beat;
          end else if (push) begin
            nxt_skid  = in_beat;
            nxt_state = TWO;
          end else if (pop) begin
            nxt_head.instr = NOP_INSTR;
            nxt_head.sb    = '0;
            nxt_state      = EMPTY;
          end
        end
        TWO: begin
          if (pop) begin
            nxt_head  = skid;
            nxt_state = ONE;
          end
        end
        default: nxt_state = EMPTY;
      endcase
    end

    nxt_valid = (nxt_state != EMPTY);
    nxt_ready = (nxt_state != TWO);
  end

  assign in_ready  = ready_q;
  assign out_valid = valid_q;
  assign InstrD    = head.instr;
  assign PCD       = head.pc;
  assign PC_Plus4D = head.pc4;
  assign SbD       = head.sb;
  assign occupancy = 2'(state);

endmodule

// File: tb/tb_pipeline_fd_skid.sv
// Directed bench for pipeline_fd_skid: default 32-bit instance plus a 64-bit parameterised instance.
module tb_pipeline_fd_skid;

  localparam logic [31:0] NOP = 32'h0000_0033;

  logic        clk;
  logic        n_rst;
  logic        in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0] InstrF, PCF, PC_Plus4F, InstrD, PCD, PC_Plus4D;
  logic [1:0]  SbF, SbD, occupancy;

  logic        in_valid64, in_ready64, flush64, out_valid64, out_ready64;
  logic [63:0] InstrF64, PCF64, PC_Plus4F64, InstrD64, PCD64, PC_Plus4D64;
  logic [3:0]  SbF64, SbD64;
  logic [1:0]  occupancy64;

  int total;
  int bad;

  pipeline_fd_skid u_dut (
    .clk(clk), .n_rst(n_rst), .in_valid(in_valid), .in_ready(in_ready),
    .InstrF(InstrF), .PCF(PCF), .PC_Plus4F(PC_Plus4F), .SbF(SbF), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .InstrD(InstrD), .PCD(PCD),
    .PC_Plus4D(PC_Plus4D), .SbD(SbD), .occupancy(occupancy)
  );

  pipeline_fd_skid #(.XLEN(64), .RESET_PC(64'h8000_0000), .SB_W(4)) u_dut64 (
    .clk(clk), .n_rst(n_rst), .in_valid(in_valid64), .in_ready(in_ready64),
    .InstrF(InstrF64), .PCF(PCF64), .PC_Plus4F(PC_Plus4F64), .SbF(SbF64), .flush(flush64),
    .out_valid(out_valid64), .out_ready(out_ready64), .InstrD(InstrD64), .PCD(PCD64),
    .PC_Plus4D(PC_Plus4D64), .SbD(SbD64), .occupancy(occupancy64)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                       input logic [1:0] sb);
    in_valid  = v;
    InstrF    = instr;
    PCF       = pc;
    PC_Plus4F = pc + 32'd4;
    SbF       = sb;
  endtask

  task automatic test_reset();
    n_rst = 1'b1;
    #1 n_rst = 1'b0;
    #1;
    total++; if (InstrD !== NOP) begin bad++; $display("FAIL rst_instr got=%h exp=%h", InstrD, NOP); end
    total++; if (PCD !== 32'h1000_0000) begin bad++; $display("FAIL rst_pcd got=%h exp=%h", PCD, 32'h1000_0000); end
    total++; if (PC_Plus4D !== 32'h1000_0004) begin bad++; $display("FAIL rst_pc4 got=%h exp=%h", PC_Plus4D, 32'h1000_0004); end
    total++; if ({out_valid, in_ready, occupancy, SbD} !== 6'b01_00_00) begin bad++; $display("FAIL rst_ctrl got=%b exp=%b", {out_valid, in_ready, occupancy, SbD}, 6'b01_00_00); end
    total++; if (PC_Plus4D64 !== 64'h8000_0004) begin bad++; $display("FAIL rst64_pc4 got=%h exp=%h", PC_Plus4D64, 64'h8000_0004); end
    total++; if (PCD64 !== 64'h8000_0000) begin bad++; $display("FAIL rst64_pcd got=%h exp=%h", PCD64, 64'h8000_0000); end
    tick();
    tick();
    n_rst = 1'b1;
    tick();
  endtask

  task automatic test_param64();
    logic [63:0] pc;
    out_ready64 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      pc          = 64'hFFFF_0000_1000_0000 + 64'(4 * i);
      in_valid64  = 1'b1;
      InstrF64    = 64'hDEAD_0000_0000_0013 + 64'(i);
      PCF64       = pc;
      PC_Plus4F64 = pc + 64'd4;
      SbF64       = 4'(i + 8);
      total++; if (in_ready64 !== 1'b1) begin bad++; $display("FAIL s64_ready i=%0d got=%b exp=1", i, in_ready64); end
      tick();
      total++; if (PCD64 !== pc) begin bad++; $display("FAIL s64_pcd i=%0d got=%h exp=%h", i, PCD64, pc); end
      total++; if (PC_Plus4D64 !== pc + 64'd4) begin bad++; $display("FAIL s64_pc4 i=%0d got=%h exp=%h", i, PC_Plus4D64, pc + 64'd4); end
      total++; if (SbD64 !== 4'(i + 8)) begin bad++; $display("FAIL s64_sb i=%0d got=%h exp=%h", i, SbD64, 4'(i + 8)); end
      total++; if (occupancy64 !== 2'd1) begin bad++; $display("FAIL s64_occ i=%0d got=%0d exp=1", i, occupancy64); end
    end
    in_valid64 = 1'b0;
    tick();
    total++; if (occupancy64 !== 2'd0) begin bad++; $display("FAIL s64_drain got=%0d exp=0", occupancy64); end
    total++; if (InstrD64 !== 64'h33) begin bad++; $display("FAIL s64_nop got=%h exp=%h", InstrD64, 64'h33); end
  endtask

  task automatic test_stream();
    logic [31:0] pc;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      pc = 32'h1000_0000 + 32'(4 * i);
      drive(1'b1, 32'h0100_0013 + 32'(i), pc, 2'(i));
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL st_ready i=%0d got=%b exp=1", i, in_ready); end
      tick();
      total++; if (PCD !== pc) begin bad++; $display("FAIL st_pcd i=%0d got=%h exp=%h", i, PCD, pc); end
      total++; if (InstrD !== 32'h0100_0013 + 32'(i)) begin bad++; $display("FAIL st_instr i=%0d got=%h exp=%h", i, InstrD, 32'h0100_0013 + 32'(i)); end
      total++; if ({out_valid, occupancy} !== 3'b1_01) begin bad++; $display("FAIL st_occ i=%0d got=%b exp=101", i, {out_valid, occupancy}); end
    end
    drive(1'b0, 32'h0, 32'h0, 2'd0);
    tick();
    total++; if ({out_valid, occupancy, SbD} !== 5'b0_00_00) begin bad++; $display("FAIL st_drain got=%b exp=00000", {out_valid, occupancy, SbD}); end
    total++; if (PCD !== 32'h1000_0008) begin bad++; $display("FAIL st_pchold got=%h exp=%h", PCD, 32'h1000_0008); end
  endtask

  task automatic test_skid();
    out_ready = 1'b0;
    drive(1'b1, 32'h0000_0A13, 32'h100, 2'd1);
    tick();
    total++; if ({occupancy, PCD} !== {2'd1, 32'h100}) begin bad++; $display("FAIL sk_a got=%0d/%h exp=1/100", occupancy, PCD); end
    drive(1'b1, 32'h0000_0B13, 32'h104, 2'd2);
    tick();
    total++; if ({occupancy, in_ready} !== 3'b10_0) begin bad++; $display("FAIL sk_full got=%b exp=100", {occupancy, in_ready}); end
    drive(1'b1, 32'h0000_0C13, 32'h108, 2'd3);
    tick();
    total++; if ({occupancy, PCD} !== {2'd2, 32'h100}) begin bad++; $display("FAIL sk_hold got=%0d/%h exp=2/100", occupancy, PCD); end
    out_ready = 1'b1;
    tick();
    total++; if ({occupancy, in_ready, PCD, InstrD, SbD} !== {2'd1, 1'b1, 32'h104, 32'h0000_0B13, 2'd2}) begin bad++; $display("FAIL sk_b got=%0d/%b/%h/%h/%0d exp=1/1/104/00000b13/2", occupancy, in_ready, PCD, InstrD, SbD); end
    tick();
    total++; if ({occupancy, PCD, InstrD, SbD} !== {2'd1, 32'h108, 32'h0000_0C13, 2'd3}) begin bad++; $display("FAIL sk_c got=%0d/%h/%h/%0d exp=1/108/00000c13/3", occupancy, PCD, InstrD, SbD); end
    drive(1'b0, 32'h0, 32'h0, 2'd0);
    tick();
    total++; if ({out_valid, occupancy, InstrD, SbD} !== {1'b0, 2'd0, NOP, 2'd0}) begin bad++; $display("FAIL sk_empty got=%b/%0d/%h/%0d exp=0/0/00000033/0", out_valid, occupancy, InstrD, SbD); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    drive(1'b1, 32'h0000_1113, 32'h200, 2'd1);
    tick();
    drive(1'b1, 32'h0000_2213, 32'h204, 2'd2);
    tick();
    total++; if (occupancy !== 2'd2) begin bad++; $display("FAIL fl_pre got=%0d exp=2", occupancy); end
    drive(1'b1, 32'h0000_3313, 32'h208, 2'd3);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    total++; if ({out_valid, in_ready, occupancy, SbD} !== 6'b01_00_00) begin bad++; $display("FAIL fl_ctrl got=%b exp=010000", {out_valid, in_ready, occupancy, SbD}); end
    total++; if ({InstrD, PCD} !== {NOP, 32'h200}) begin bad++; $display("FAIL fl_data got=%h/%h exp=00000033/200", InstrD, PCD); end
    drive(1'b0, 32'h0, 32'h0, 2'd0);
    out_ready = 1'b1;
    tick();
    total++; if ({out_valid, occupancy, PCD} !== {1'b0, 2'd0, 32'h200}) begin bad++; $display("FAIL fl_gone got=%b/%0d/%h exp=0/0/200", out_valid, occupancy, PCD); end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();
    total++; if ({out_valid, occupancy, InstrD, PCD, PC_Plus4D} !== {1'b0, 2'd0, NOP, 32'h200, 32'h204}) begin bad++; $display("FAIL fl_idle got=%b/%0d/%h/%h/%h exp=0/0/00000033/200/204", out_valid, occupancy, InstrD, PCD, PC_Plus4D); end
  endtask

  task automatic test_simul();
    out_ready = 1'b0;
    drive(1'b1, 32'h0000_4413, 32'h300, 2'd1);
    tick();
    total++; if ({occupancy, PCD} !== {2'd1, 32'h300}) begin bad++; $display("FAIL sm_a got=%0d/%h exp=1/300", occupancy, PCD); end
    out_ready = 1'b1;
    drive(1'b1, 32'h0000_5513, 32'h304, 2'd2);
    tick();
    total++; if ({occupancy, PCD, InstrD, SbD} !== {2'd1, 32'h304, 32'h0000_5513, 2'd2}) begin bad++; $display("FAIL sm_b got=%0d/%h/%h/%0d exp=1/304/00005513/2", occupancy, PCD, InstrD, SbD); end
    drive(1'b0, 32'h0, 32'h0, 2'd0);
    tick();
    total++; if (occupancy !== 2'd0) begin bad++; $display("FAIL sm_drain got=%0d exp=0", occupancy); end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    drive(1'b1, 32'h0000_6613, 32'h400, 2'd1);
    tick();
    drive(1'b1, 32'h0000_7713, 32'h404, 2'd2);
    tick();
    drive(1'b0, 32'h0, 32'h0, 2'd0);
    #2 n_rst = 1'b0;
    #1;
    total++; if ({InstrD, PCD, PC_Plus4D} !== {NOP, 32'h1000_0000, 32'h1000_0004}) begin bad++; $display("FAIL rm_data got=%h/%h/%h exp=00000033/10000000/10000004", InstrD, PCD, PC_Plus4D); end
    total++; if ({out_valid, in_ready, occupancy} !== 4'b01_00) begin bad++; $display("FAIL rm_ctrl got=%b exp=0100", {out_valid, in_ready, occupancy}); end
    tick();
    n_rst = 1'b1;
    drive(1'b1, 32'h0000_8813, 32'h500, 2'd3);
    tick();
    total++; if ({occupancy, PCD, InstrD} !== {2'd1, 32'h500, 32'h0000_8813}) begin bad++; $display("FAIL rm_push got=%0d/%h/%h exp=1/500/00008813", occupancy, PCD, InstrD); end
    drive(1'b0, 32'h0, 32'h0, 2'd0);
    out_ready = 1'b1;
    tick();
    total++; if (occupancy !== 2'd0) begin bad++; $display("FAIL rm_drain got=%0d exp=0", occupancy); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    flush = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 2'd0);
    in_valid64 = 1'b0; flush64 = 1'b0; out_ready64 = 1'b0;
    InstrF64 = '0; PCF64 = '0; PC_Plus4F64 = '0; SbF64 = '0;
    test_reset();
    test_param64();
    test_stream();
    test_skid();
    test_flush();
    test_simul();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
